// File: rtl/sc_road_sequencer.sv
// Game-flow sequencer for the road display: drives per-row mux selects and
// walks IDLE -> CLEAR -> PLAY -> CRASH/WIN from scroll ticks and collisions.
module sc_road_sequencer #(
  parameter int ROWS = 8,
  parameter int SELW = 2,
  parameter int CNTW = 8,
  parameter int GOAL = 200
) (
  input  logic                   SC_ROADSEQ_CLOCK_50,
  input  logic                   SC_ROADSEQ_RESET_InHigh,
  input  logic                   SC_ROADSEQ_START_InLow,
  input  logic                   SC_ROADSEQ_TICK_In,
  input  logic                   SC_ROADSEQ_CRASH_In,
  output logic [ROWS*SELW-1:0]   SC_ROADSEQ_SEL_Out,
  output logic [2:0]             SC_ROADSEQ_STATE_Out,
  output logic [CNTW-1:0]        SC_ROADSEQ_SCORE_Out,
  output logic                   SC_ROADSEQ_WIN_Out,
  output logic                   SC_ROADSEQ_LOSE_Out
);

  // state | meaning
  // IDLE  | waiting for a start press, road cleared
  // CLEAR | one-cycle wipe of the road and score
  // PLAY  | scrolling on ticks, collisions checked once road is full
  // CRASH | frozen display, lose flag up
  // WIN   | frozen display, win flag up
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_CRASH = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;

  localparam logic [SELW-1:0] SEL_CLEAR = SELW'(0);
  localparam logic [SELW-1:0] SEL_HOLD  = SELW'(1);
  localparam logic [SELW-1:0] SEL_LOAD  = SELW'(2);
  localparam logic [SELW-1:0] SEL_SHIFT = SELW'(3);

  localparam logic [CNTW-1:0] ROWS_C  = CNTW'(ROWS);
  localparam logic [CNTW-1:0] GOAL_M1 = CNTW'(GOAL - 1);

  logic [2:0]            state_q, state_d;
  logic                  start_q;
  logic [CNTW-1:0]       score_q, score_d;
  logic [ROWS*SELW-1:0]  sel_q, sel_d;
  logic [ROWS*SELW-1:0]  scroll_pat, hold_pat;
  logic                  press_w, eff_crash_w, scroll_w;

  always_comb begin
    scroll_pat = '0;
    hold_pat   = '0;
    for (int r = 0; r < ROWS; r++) begin
      scroll_pat[r*SELW +: SELW] = (r == 0) ? SEL_LOAD : SEL_SHIFT;
      hold_pat[r*SELW +: SELW]   = SEL_HOLD;
    end
  end

  assign press_w     = start_q & ~SC_ROADSEQ_START_InLow;
  // Collisions are ignored until every row has been loaded at least once.
  assign eff_crash_w = SC_ROADSEQ_CRASH_In && (score_q >= ROWS_C);
  assign scroll_w    = (state_q == ST_PLAY) && SC_ROADSEQ_TICK_In && !eff_crash_w;

  always_ff @(posedge SC_ROADSEQ_CLOCK_50) begin
    if (SC_ROADSEQ_RESET_InHigh) begin
      state_q <= ST_IDLE;
      start_q <= 1'b1;
      score_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= SC_ROADSEQ_START_InLow;
      score_q <= score_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (press_w) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_PLAY;
      ST_PLAY: begin
        if (eff_crash_w)
          state_d = ST_CRASH;
        else if (SC_ROADSEQ_TICK_In && (score_q == GOAL_M1))
          state_d = ST_WIN;
      end
      ST_CRASH, ST_WIN: if (press_w) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Selects and score are computed for the upcoming state so they register
  // alongside it; the final winning tick still produces its scroll.
  always_comb begin
    score_d = score_q;
    sel_d   = hold_pat;
    if ((state_d == ST_IDLE) || (state_d == ST_CLEAR)) begin
      score_d = '0;
      sel_d   = '0;
    end else if (scroll_w) begin
      score_d = score_q + CNTW'(1);
      sel_d   = scroll_pat;
    end
  end

  assign SC_ROADSEQ_SEL_Out   = sel_q;
  assign SC_ROADSEQ_STATE_Out = state_q;
  assign SC_ROADSEQ_SCORE_Out = score_q;
  assign SC_ROADSEQ_WIN_Out   = (state_q == ST_WIN);
  assign SC_ROADSEQ_LOSE_Out  = (state_q == ST_CRASH);

endmodule

// File: tb/tb_sc_road_sequencer.sv
// Scoreboard bench for sc_road_sequencer: a game-level model predicts each
// cycle's outputs, a monitor compares them after every rising edge.
module tb_sc_road_sequencer;
  localparam int ROWS = 8;
  localparam int SELW = 2;
  localparam int CNTW = 8;
  localparam int GOAL = 10;
  localparam int SW   = ROWS * SELW;

  logic clk = 1'b0;
  logic rst, start_n, tick, crash;
  logic [SW-1:0]   sel;
  logic [2:0]      st;
  logic [CNTW-1:0] score;
  logic            win, lose;

  always #5 clk = ~clk;

  sc_road_sequencer #(.ROWS(ROWS), .SELW(SELW), .CNTW(CNTW), .GOAL(GOAL)) dut (
    .SC_ROADSEQ_CLOCK_50    (clk),
    .SC_ROADSEQ_RESET_InHigh(rst),
    .SC_ROADSEQ_START_InLow (start_n),
    .SC_ROADSEQ_TICK_In     (tick),
    .SC_ROADSEQ_CRASH_In    (crash),
    .SC_ROADSEQ_SEL_Out     (sel),
    .SC_ROADSEQ_STATE_Out   (st),
    .SC_ROADSEQ_SCORE_Out   (score),
    .SC_ROADSEQ_WIN_Out     (win),
    .SC_ROADSEQ_LOSE_Out    (lose)
  );

  typedef struct {
    logic [2:0]      st;
    logic [SW-1:0]   sel;
    logic [CNTW-1:0] score;
    logic            win;
    logic            lose;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Game-level reference: mode 0 idle, 1 clear, 2 play, 3 crash, 4 win.
  int m_mode = 0;
  int m_score = 0;
  bit m_prev = 1'b1;
  bit m_scroll = 1'b0;

  function automatic logic [SW-1:0] pattern(input int kind);
    logic [SW-1:0] p;
    p = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (kind == 1)      p[r*SELW +: SELW] = SELW'(1);
      else if (kind == 2) p[r*SELW +: SELW] = (r == 0) ? SELW'(2) : SELW'(3);
    end
    return p;
  endfunction

  task automatic model_step(input bit r, input bit sn, input bit tk, input bit cr);
    bit press;
    exp_t e;
    m_scroll = 1'b0;
    if (r) begin
      m_mode = 0; m_score = 0; m_prev = 1'b1;
    end else begin
      press  = m_prev && !sn;
      m_prev = sn;
      case (m_mode)
        0: if (press) m_mode = 1;
        1: m_mode = 2;
        2: begin
          if (cr && m_score >= ROWS) m_mode = 3;
          else if (tk) begin
            m_score++;
            m_scroll = 1'b1;
            if (m_score == GOAL) m_mode = 4;
          end
        end
        default: if (press) m_mode = 1;
      endcase
      if (m_mode <= 1) m_score = 0;
    end
    e.st    = 3'(m_mode);
    e.score = CNTW'(m_score);
    e.sel   = m_scroll ? pattern(2) : ((m_mode <= 1) ? pattern(0) : pattern(1));
    e.win   = (m_mode == 4);
    e.lose  = (m_mode == 3);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit sn, input bit tk, input bit cr);
    @(negedge clk);
    rst = r; start_n = sn; tick = tk; crash = cr;
    model_step(r, sn, tk, cr);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (st !== e.st || sel !== e.sel || score !== e.score ||
            win !== e.win || lose !== e.lose) begin
          n_fail++;
          $display("FAIL cycle%0d: got st=%0d sel=%h score=%0d win=%b lose=%b, expected st=%0d sel=%h score=%0d win=%b lose=%b",
                   cyc, st, sel, score, win, lose, e.st, e.sel, e.score, e.win, e.lose);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; start_n = 1'b1; tick = 1'b0; crash = 1'b0;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < GOAL; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(7) != 0),
           ($urandom_range(2) == 0),
           ($urandom_range(7) == 0));
    end
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
